lsu_align_unit: RTL and testbench
=================================

Name: lsu_align_unit

Overview:
- Parametrised load/store unit that sits between the execute stage and the data-memory port.
- Executes one memory access per request, using the core's mem_access_type encoding extended for 64-bit.
- Handles sub-word extraction with sign/zero extension and store byte strobes.
- Optionally splits misaligned accesses into two aligned bus beats; when split support is disabled, it raises a fault instead.

Parameters:
- XLEN, 32, datapath and address width; 32 or 64 only.
- MISALIGNED_SPLIT, 1, 1 = split misaligned accesses into two beats; 0 = report misaligned accesses as faults.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_op  in  4  access type: LB=0 LH=1 LW=2 LBU=3 LHU=4 SB=5 SH=6 SW=7 MEM_NONE=8 LD=9 LWU=10 SD=11.
- req_addr  in  XLEN  byte address.
- req_wdata  in  XLEN  store data, LSB-aligned.
- resp_valid  out  1  single-cycle completion pulse.
- resp_rdata  out  XLEN  extended load result; 0 for stores, MEM_NONE and faults.
- resp_fault  out  1  misaligned access with MISALIGNED_SPLIT=0, or illegal op; valid only with resp_valid.
- mem_req  out  1  bus request.
- mem_we  out  1  write enable.
- mem_addr  out  XLEN  word-aligned address; low log2(XLEN/8) bits are 0.
- mem_wdata  out  XLEN  lane-positioned write data.
- mem_wstrb  out  XLEN/8  byte strobes; all 0 on reads.
- mem_ack  in  1  bus completion; for reads, mem_rdata is valid in the ack cycle.
- mem_rdata  in  XLEN  read data.

Behaviour:
- Reset: state IDLE; req_ready=1; resp_valid=0; resp_fault=0; mem_req=0; mem_we=0; mem_wstrb=0; resp_rdata=0; mem_addr=0; mem_wdata=0.
- States: IDLE, BEAT0, BEAT1, RESP.
- IDLE: req_ready=1. A request is accepted on clk when req_valid && req_ready; op, address, data and derived size are latched at acceptance.
- Derived quantities: B = XLEN/8; off = addr mod B; size = 1/2/4/8 bytes.
- Illegal ops: op values 12-15, and ops 9-11 when XLEN=32. An illegal op goes straight to RESP with fault=1 and issues no bus traffic.
- MEM_NONE goes to RESP with fault=0 and issues no bus traffic.
- Misaligned means off+size > B. With MISALIGNED_SPLIT=0, a misaligned access goes to RESP with fault=1 and no bus traffic.
- Otherwise the unit moves to BEAT0.
- BEAT0: mem_req=1 with mem_addr = addr & ~(B-1).
  - Store lanes: mem_wdata = wdata << 8*off; mem_wstrb = ((1<<size)-1) << off, truncated to B bits.
  - All bus outputs are held stable until mem_ack.
  - On ack: the beat data is captured. If the access is misaligned, go to BEAT1; otherwise go to RESP.
- BEAT1: mem_addr = aligned addr + B, wrapping modulo 2^XLEN.
  - Store lanes: mem_wdata = wdata >> 8*(B-off); mem_wstrb = ((1<<size)-1) >> (B-off).
  - On ack: go to RESP.
- Load assembly: raw = {beat1, beat0} >> 8*off, truncated to size bytes.
- Load extension: sign-extend for LB/LH/LW; zero-extend for LBU/LHU/LWU. LD takes all 64 bits.
- RESP: resp_valid=1 for exactly one cycle; req_ready=0; then return to IDLE.
  - A new request is accepted at the earliest in the following IDLE cycle.
- mem_req deasserts in the cycle after the final ack, so there are no back-to-back beats across requests.
- Latency from acceptance edge to resp_valid:
  - Aligned access: 2 + wait cycles, where wait is the number of cycles mem_req is high before mem_ack.
  - Split access: 3 + total wait cycles.
  - Bypass (MEM_NONE, fault): 1 cycle.
- mem_ack while mem_req=0 is ignored.
- req_valid while req_ready=0 is ignored; the requester holds it.
- Reset mid-access drops the access immediately: mem_req falls asynchronously and no response is produced.

Test Plan:
- Aligned LW addr 0x100, mem_rdata 0x8000_00F0, ack in the first request cycle -> one beat, mem_addr=0x100, resp_rdata=0x8000_00F0, resp_valid exactly 2 cycles after acceptance.
- LB addr 0x103, rdata 0x8A00_0000 -> resp_rdata=0xFFFF_FF8A. LBU at the same address -> 0x0000_008A.
- SH addr 0x102, wdata 0x1234 -> mem_wdata=0x1234_0000, mem_wstrb=4'b1100, mem_we=1, resp_rdata=0.
- Split LW addr 0x106, beat0 rdata 0xBBAA_0000, beat1 rdata 0x0000_DDCC -> mem_addr 0x104 then 0x108, resp_rdata=0xDDCC_BBAA.
- Split SW addr 0x107, wdata 0x4433_2211 -> beat0 wstrb=1000, wdata=0x1100_0000; beat1 wstrb=0111, wdata=0x0044_3322.
- MISALIGNED_SPLIT=0, LH addr 0x1FF -> no mem_req, resp_fault=1 one cycle after acceptance. Separately, assert rst while mem_req=1 -> mem_req=0 immediately and no resp_valid afterwards.

Source files
------------

// File: rtl/lsu_align_unit.sv
// Load/store alignment unit: sub-word extraction, sign/zero extension and byte
// strobes. Misaligned accesses are either split into two aligned bus beats or
// reported as faults.
//
// state | meaning
// IDLE  | ready for a new request
// BEAT0 | first (or only) aligned bus beat in flight
// BEAT1 | second beat of a split misaligned access
// RESP  | one-cycle completion pulse
module lsu_align_unit #(
  parameter int XLEN             = 32,
  parameter bit MISALIGNED_SPLIT = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_fault,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wstrb,
  input  logic              mem_ack,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int B  = XLEN / 8;
  localparam int OW = $clog2(B);

  localparam logic [3:0] OP_LB  = 4'd0;
  localparam logic [3:0] OP_LH  = 4'd1;
  localparam logic [3:0] OP_LW  = 4'd2;
  localparam logic [3:0] OP_LBU = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_SB  = 4'd5;
  localparam logic [3:0] OP_SH  = 4'd6;
  localparam logic [3:0] OP_SW  = 4'd7;
  localparam logic [3:0] OP_NONE = 4'd8;
  localparam logic [3:0] OP_LD  = 4'd9;
  localparam logic [3:0] OP_LWU = 4'd10;
  localparam logic [3:0] OP_SD  = 4'd11;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  state_t state, state_nxt;

  logic [3:0]      op_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] beat0_q;
  logic [XLEN-1:0] rdata_q;
  logic [3:0]      size_q;
  logic            split_q;
  logic            fault_q;

  logic [3:0]      req_size;
  logic            req_illegal;
  logic            req_mis;
  logic [OW-1:0]   off_q;
  logic            store_q;
  logic [XLEN-1:0] addr_aligned;

  logic [2*XLEN-1:0] wide_data;
  logic [2*B-1:0]    strb_mask;
  logic [2*B-1:0]    wide_strb;
  logic [2*XLEN-1:0] beats;
  logic [XLEN-1:0]   raw;
  logic [XLEN-1:0]   load_result;

  // Decode the incoming request: access size, legality and misalignment.
  always_comb begin
    req_size    = 4'd0;
    req_illegal = 1'b0;
    case (req_op)
      OP_LB, OP_LBU, OP_SB:  req_size = 4'd1;
      OP_LH, OP_LHU, OP_SH:  req_size = 4'd2;
      OP_LW, OP_LWU, OP_SW:  req_size = 4'd4;
      OP_LD, OP_SD:          req_size = 4'd8;
      OP_NONE:               req_size = 4'd0;
      default:               req_illegal = 1'b1;
    endcase
    // 64-bit ops do not exist on a 32-bit datapath
    if (XLEN == 32 && (req_op == OP_LD || req_op == OP_LWU || req_op == OP_SD)) begin
      req_illegal = 1'b1;
      req_size    = 4'd0;
    end
    req_mis = (5'(req_addr[OW-1:0]) + 5'(req_size)) > 5'(B);
  end

  // State register; reset aborts any in-flight access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    mem_req    = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_illegal || req_op == OP_NONE || (req_mis && !MISALIGNED_SPLIT))
            state_nxt = RESP;
          else
            state_nxt = BEAT0;
        end
      end
      BEAT0: begin
        mem_req = 1'b1;
        if (mem_ack) state_nxt = split_q ? BEAT1 : RESP;
      end
      BEAT1: begin
        mem_req = 1'b1;
        if (mem_ack) state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Lane placement for stores and byte-shifted assembly for loads. Stores are
  // positioned in a double-width window so the upper half is the second beat.
  always_comb begin
    off_q        = addr_q[OW-1:0];
    store_q      = (op_q == OP_SB) || (op_q == OP_SH) || (op_q == OP_SW) || (op_q == OP_SD);
    addr_aligned = {addr_q[XLEN-1:OW], {OW{1'b0}}};
    wide_data    = {{XLEN{1'b0}}, wdata_q} << {off_q, 3'b000};
    strb_mask    = ((2*B)'(1) << size_q) - (2*B)'(1);
    wide_strb    = strb_mask << off_q;
    beats        = (state == BEAT1) ? {mem_rdata, beat0_q} : {{XLEN{1'b0}}, mem_rdata};
    raw          = XLEN'(beats >> {off_q, 3'b000});
    case (op_q)
      OP_LB:   load_result = XLEN'($signed(raw[7:0]));
      OP_LBU:  load_result = XLEN'(raw[7:0]);
      OP_LH:   load_result = XLEN'($signed(raw[15:0]));
      OP_LHU:  load_result = XLEN'(raw[15:0]);
      OP_LW:   load_result = XLEN'($signed(raw[31:0]));
      OP_LWU:  load_result = XLEN'(raw[31:0]);
      OP_LD:   load_result = raw;
      default: load_result = '0;
    endcase
  end

  // Bus-side outputs are zero outside the beat states.
  always_comb begin
    mem_we    = mem_req && store_q;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    if (state == BEAT0) begin
      mem_addr = addr_aligned;
      if (store_q) begin
        mem_wdata = wide_data[XLEN-1:0];
        mem_wstrb = wide_strb[B-1:0];
      end
    end else if (state == BEAT1) begin
      mem_addr = addr_aligned + XLEN'(B);
      if (store_q) begin
        mem_wdata = wide_data[2*XLEN-1:XLEN];
        mem_wstrb = wide_strb[2*B-1:B];
      end
    end
    resp_rdata = (state == RESP) ? rdata_q : '0;
    resp_fault = (state == RESP) && fault_q;
  end

  // Request latch, first-beat capture and result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      beat0_q <= '0;
      rdata_q <= '0;
      size_q  <= 4'd0;
      split_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) begin
        op_q    <= req_op;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        size_q  <= req_size;
        split_q <= req_mis;
        fault_q <= req_illegal || (req_mis && !MISALIGNED_SPLIT);
        rdata_q <= '0;
      end
      if (state == BEAT0 && mem_ack) beat0_q <= mem_rdata;
      if ((state == BEAT0 && mem_ack && !split_q) || (state == BEAT1 && mem_ack))
        rdata_q <= load_result;
    end
  end

endmodule

// File: tb/tb_lsu_align_unit.sv
// Scoreboard bench: stimulus pushes expected responses and bus beats into
// queues; a bus responder and response monitors pop and compare.
module tb_lsu_align_unit;

  logic        clk, rst;
  logic        req_valid, req_valid_ns;
  logic        req_ready, req_ready_ns;
  logic [3:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_fault, resp_valid_ns, resp_fault_ns;
  logic [31:0] resp_rdata, resp_rdata_ns;
  logic        mem_req, mem_we, mem_ack, mem_req_ns, mem_we_ns, mem_ack_ns;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, mem_addr_ns, mem_wdata_ns, mem_rdata_ns;
  logic [3:0]  mem_wstrb, mem_wstrb_ns;

  int checks = 0;
  int errors = 0;
  bit ns_req_seen = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          lat;
    time         acc_t;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    int          wait_n;
  } beat_t;

  exp_t  exp_q[$];
  exp_t  exp_ns_q[$];
  beat_t bus_q[$];

  lsu_align_unit #(.XLEN(32), .MISALIGNED_SPLIT(1'b1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  lsu_align_unit #(.XLEN(32), .MISALIGNED_SPLIT(1'b0)) dut_ns (
    .clk(clk), .rst(rst), .req_valid(req_valid_ns), .req_ready(req_ready_ns),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid_ns), .resp_rdata(resp_rdata_ns), .resp_fault(resp_fault_ns),
    .mem_req(mem_req_ns), .mem_we(mem_we_ns), .mem_addr(mem_addr_ns), .mem_wdata(mem_wdata_ns),
    .mem_wstrb(mem_wstrb_ns), .mem_ack(mem_ack_ns), .mem_rdata(mem_rdata_ns)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic bp(input logic we, input logic [31:0] a, input logic [31:0] wd,
                    input logic [3:0] st, input logic [31:0] rd, input int w);
    beat_t b;
    b.we = we; b.addr = a; b.wdata = wd; b.wstrb = st; b.rdata = rd; b.wait_n = w;
    bus_q.push_back(b);
  endtask

  task automatic issue(input bit ns, input bit push, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] er, input logic ef, input int lat);
    exp_t e;
    bit   rdy;
    int   n;
    @(posedge clk); #1;
    req_op = op; req_addr = a; req_wdata = wd;
    if (ns) req_valid_ns = 1'b1; else req_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      rdy = ns ? req_ready_ns : req_ready;
      @(posedge clk);
      if (rdy) break;
      n++;
      if (n > 200) begin
        checks++; errors++;
        $display("FAIL accept_timeout: op %0d not accepted", op);
        break;
      end
    end
    e.rdata = er; e.fault = ef; e.lat = lat; e.acc_t = $time;
    if (push && n <= 200) begin
      if (ns) exp_ns_q.push_back(e); else exp_q.push_back(e);
    end
    #1;
    req_valid = 1'b0; req_valid_ns = 1'b0;
  endtask

  // Bus responder: checks each beat's request fields, then acks after wait_n cycles.
  initial begin
    beat_t cur;
    bit    active;
    int    wcnt;
    mem_ack = 1'b0; mem_rdata = '0; active = 0; wcnt = 0;
    cur = '{we: 1'b0, addr: '0, wdata: '0, wstrb: '0, rdata: '0, wait_n: 0};
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_req) begin
        if (!active) begin
          if (bus_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL bus_unexpected: addr %h", mem_addr);
            cur = '{we: mem_we, addr: mem_addr, wdata: mem_wdata, wstrb: mem_wstrb, rdata: '0, wait_n: 0};
          end else begin
            cur = bus_q.pop_front();
          end
          active = 1; wcnt = 0;
        end
        chk("bus_we", {31'b0, mem_we}, {31'b0, cur.we});
        chk("bus_addr", mem_addr, cur.addr);
        chk("bus_wstrb", {28'b0, mem_wstrb}, {28'b0, cur.wstrb});
        if (cur.we) chk("bus_wdata", mem_wdata, cur.wdata);
        if (wcnt == cur.wait_n) begin
          mem_ack = 1'b1; mem_rdata = cur.rdata; active = 0;
        end else begin
          wcnt++;
        end
      end else begin
        active = 0;
      end
    end
  end

  // Response monitor for the splitting instance.
  always @(negedge clk) begin
    exp_t e;
    if (resp_valid) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL resp_unexpected: rdata %h", resp_rdata);
      end else begin
        e = exp_q.pop_front();
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_fault", {31'b0, resp_fault}, {31'b0, e.fault});
        chk("resp_latency", 32'(($time + 5 - e.acc_t) / 10), 32'(e.lat));
      end
    end
  end

  // Response monitor for the fault-on-misalign instance.
  always @(negedge clk) begin
    exp_t e;
    if (mem_req_ns) ns_req_seen = 1;
    if (resp_valid_ns) begin
      if (exp_ns_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL ns_resp_unexpected: rdata %h", resp_rdata_ns);
      end else begin
        e = exp_ns_q.pop_front();
        chk("ns_resp_rdata", resp_rdata_ns, e.rdata);
        chk("ns_resp_fault", {31'b0, resp_fault_ns}, {31'b0, e.fault});
        chk("ns_resp_latency", 32'(($time + 5 - e.acc_t) / 10), 32'(e.lat));
      end
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_ns_q.size() != 0 || bus_q.size() != 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_valid_ns = 1'b0;
    req_op = 4'd8; req_addr = '0; req_wdata = '0;
    mem_ack_ns = 1'b0; mem_rdata_ns = '0;

    @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_fault", {31'b0, resp_fault}, 32'd0);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_wstrb", {28'b0, mem_wstrb}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    #3 rst = 1'b0;

    // aligned LW, ack in first request cycle
    bp(0, 32'h100, 32'h0, 4'b0000, 32'h8000_00F0, 0);
    issue(0, 1, 4'd2, 32'h100, 32'h0, 32'h8000_00F0, 0, 2);
    // LB / LBU sub-word extraction
    bp(0, 32'h100, 32'h0, 4'b0000, 32'h8A00_0000, 0);
    issue(0, 1, 4'd0, 32'h103, 32'h0, 32'hFFFF_FF8A, 0, 2);
    bp(0, 32'h100, 32'h0, 4'b0000, 32'h8A00_0000, 2);
    issue(0, 1, 4'd3, 32'h103, 32'h0, 32'h0000_008A, 0, 4);
    // aligned LH with sign extension at offset 1
    bp(0, 32'h100, 32'h0, 4'b0000, 32'h1280_0134, 0);
    issue(0, 1, 4'd1, 32'h101, 32'h0, 32'hFFFF_8001, 0, 2);
    // SH and SB lane placement
    bp(1, 32'h100, 32'h1234_0000, 4'b1100, 32'h0, 0);
    issue(0, 1, 4'd6, 32'h102, 32'h1234, 32'h0, 0, 2);
    bp(1, 32'h100, 32'h0000_A500, 4'b0010, 32'h0, 1);
    issue(0, 1, 4'd5, 32'h101, 32'hA5, 32'h0, 0, 3);
    // split LW
    bp(0, 32'h104, 32'h0, 4'b0000, 32'hBBAA_0000, 0);
    bp(0, 32'h108, 32'h0, 4'b0000, 32'h0000_DDCC, 0);
    issue(0, 1, 4'd2, 32'h106, 32'h0, 32'hDDCC_BBAA, 0, 3);
    // split SW with a wait on the second beat
    bp(1, 32'h104, 32'h1100_0000, 4'b1000, 32'h0, 0);
    bp(1, 32'h108, 32'h0044_3322, 4'b0111, 32'h0, 1);
    issue(0, 1, 4'd7, 32'h107, 32'h4433_2211, 32'h0, 0, 4);
    // split LHU crossing a word
    bp(0, 32'h100, 32'h0, 4'b0000, 32'hAB00_0000, 0);
    bp(0, 32'h104, 32'h0, 4'b0000, 32'h0000_00CD, 0);
    issue(0, 1, 4'd4, 32'h103, 32'h0, 32'h0000_CDAB, 0, 3);
    // split LW wrapping around the top of the address space
    bp(0, 32'hFFFF_FFFC, 32'h0, 4'b0000, 32'h5566_0000, 0);
    bp(0, 32'h0000_0000, 32'h0, 4'b0000, 32'h0000_7788, 0);
    issue(0, 1, 4'd2, 32'hFFFF_FFFE, 32'h0, 32'h7788_5566, 0, 3);
    // bypass: MEM_NONE, LD on 32-bit, reserved op
    issue(0, 1, 4'd8, 32'h100, 32'h0, 32'h0, 0, 1);
    issue(0, 1, 4'd9, 32'h100, 32'h0, 32'h0, 1, 1);
    issue(0, 1, 4'd14, 32'h100, 32'h0, 32'h0, 1, 1);
    // misaligned LH with splitting disabled
    issue(1, 1, 4'd1, 32'h1FF, 32'h0, 32'h0, 1, 1);
    drain();

    // reset mid-access: no response may follow
    bp(0, 32'h200, 32'h0, 4'b0000, 32'h0, 10);
    issue(0, 0, 4'd2, 32'h200, 32'h0, 32'h0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("mid_mem_req", {31'b0, mem_req}, 32'd1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("rst_async_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_async_resp_valid", {31'b0, resp_valid}, 32'd0);
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("post_rst_req_ready", {31'b0, req_ready}, 32'd1);

    drain();
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    chk("exp_ns_q_empty", 32'(exp_ns_q.size()), 32'd0);
    chk("bus_q_empty", 32'(bus_q.size()), 32'd0);
    chk("ns_no_mem_req", {31'b0, ns_req_seen}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

endmodule
